// File: rtl/sobol_rng_gen.sv
// sobol_rng_gen: one-dimension Sobol sequence generator, width-generic.
// Each enabled cycle the lowest zero bit of the point counter selects a
// direction vector that is XORed into the running Sobol state.  When the
// counter is all ones the period is complete: state and counter return to 0
// and wrap pulses for one cycle.
// Optional feature macro: SOBOL_DIRLOAD_EN -- direction vectors become a
// run-time writable register file (dirWe/dirIdx/dirData).  Without it the
// vectors are the constant dimension-1 set and the write port is ignored.
// No handshake: every cycle with enable=1 consumes exactly one point, and
// all outputs reflect that point one cycle after the enable edge.
module sobol_rng_gen #(
    parameter  int WIDTH = 8,
    localparam int LOGW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             dirWe,
    input  logic [LOGW-1:0]  dirIdx,
    input  logic [WIDTH-1:0] dirData,
    output logic [WIDTH-1:0] sobolOut,
    output logic [WIDTH-1:0] cntOut,
    output logic [LOGW-1:0]  lszIdx,
    output logic             wrap
);

    // Dimension-1 direction vector k: a single bit walking down from the MSB.
    function automatic logic [WIDTH-1:0] default_vec(input int k);
        return WIDTH'(1) << (WIDTH - 1 - k);
    endfunction

    logic [WIDTH-1:0] sobol_q, sobol_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [LOGW-1:0]  lsz_idx_q, lsz_idx_d;
    logic             wrap_q, wrap_d;

    logic [LOGW-1:0]  lsz;
    logic             cnt_all_ones;
    logic [WIDTH-1:0] sel_vec;
    logic [WIDTH-1:0] dir_vec [WIDTH];

`ifdef SOBOL_DIRLOAD_EN
    logic [WIDTH-1:0] dir_q [WIDTH];
    logic [WIDTH-1:0] dir_d [WIDTH];

    // Direction-vector write port; out-of-range indices match no entry.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            dir_d[k] = dir_q[k];
            if (dirWe && (dirIdx == LOGW'(k))) begin
                dir_d[k] = dirData;
            end
        end
    end

    // Direction-vector storage, restored to dimension 1 on reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (rst) begin
                dir_q[k] <= default_vec(k);
            end else begin
                dir_q[k] <= dir_d[k];
            end
        end
    end

    // The advance reads the stored vectors, so a same-cycle write is seen next cycle.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            dir_vec[k] = dir_q[k];
        end
    end
`else
    logic unused_dir_port;
    assign unused_dir_port = ^{dirWe, dirIdx, dirData};

    // Constant dimension-1 vectors; no storage.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            dir_vec[k] = default_vec(k);
        end
    end
`endif

    // Priority chain: index of the lowest zero bit of the counter, WIDTH if none.
    always_comb begin
        lsz = LOGW'(WIDTH);
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (!cnt_q[k]) begin
                lsz = LOGW'(k);
            end
        end
    end

    assign cnt_all_ones = &cnt_q;

    // WIDTH:1 mux selecting the direction vector addressed by the chain.
    always_comb begin
        sel_vec = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (lsz == LOGW'(k)) begin
                sel_vec = dir_vec[k];
            end
        end
    end

    // Next point: XOR step, or return to zero at the end of the period.
    always_comb begin
        sobol_d   = sobol_q;
        cnt_d     = cnt_q;
        lsz_idx_d = lsz_idx_q;
        wrap_d    = 1'b0;
        if (enable) begin
            lsz_idx_d = lsz;
            if (cnt_all_ones) begin
                sobol_d = '0;
                cnt_d   = '0;
                wrap_d  = 1'b1;
            end else begin
                sobol_d = sobol_q ^ sel_vec;
                cnt_d   = cnt_q + WIDTH'(1);
            end
        end
    end

    // Output state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sobol_q   <= '0;
            cnt_q     <= '0;
            lsz_idx_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            sobol_q   <= sobol_d;
            cnt_q     <= cnt_d;
            lsz_idx_q <= lsz_idx_d;
            wrap_q    <= wrap_d;
        end
    end

    assign sobolOut = sobol_q;
    assign cntOut   = cnt_q;
    assign lszIdx   = lsz_idx_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_sobol_rng_gen.sv
// Bench for sobol_rng_gen: a WIDTH=3 and a WIDTH=8 instance run side by side
// on one clock, each against its own behavioural model via expected queues.
module tb_sobol_rng_gen;
    localparam int EW = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en3 = 1'b0;
    logic       en8 = 1'b0;
    logic       we3 = 1'b0;
    logic [1:0] idx3 = '0;
    logic [2:0] data3 = '0;
    logic       we8 = 1'b0;
    logic [3:0] idx8 = '0;
    logic [7:0] data8 = '0;

    logic [2:0] sobol3, cnt3;
    logic [1:0] lsz3;
    logic       wrap3;
    logic [7:0] sobol8, cnt8;
    logic [3:0] lsz8;
    logic       wrap8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q3[$];
    logic [EW-1:0] exp_q8[$];

    // Model state per instance: 0 = WIDTH 3, 1 = WIDTH 8.
    int m_s[2];
    int m_c[2];
    int m_l[2];
    int m_w[2];
    int m_v[2][16];

    sobol_rng_gen #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .enable(en3), .dirWe(we3), .dirIdx(idx3),
        .dirData(data3), .sobolOut(sobol3), .cntOut(cnt3), .lszIdx(lsz3),
        .wrap(wrap3)
    );

    sobol_rng_gen #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .enable(en8), .dirWe(we8), .dirIdx(idx8),
        .dirData(data8), .sobolOut(sobol8), .cntOut(cnt8), .lszIdx(lsz8),
        .wrap(wrap8)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: lowest zero of the counter picks a vector,
    // the all-ones counter ends the period; writes land after the advance.
    task automatic model_step(input int d, input int w, input bit r, input bit en,
                              input bit we, input int idx, input int data,
                              output logic [EW-1:0] e);
        int lsz;
        if (r) begin
            m_s[d] = 0; m_c[d] = 0; m_l[d] = 0; m_w[d] = 0;
            for (int k = 0; k < w; k++) m_v[d][k] = 1 << (w - 1 - k);
        end else begin
            if (en) begin
                lsz = w;
                for (int k = w - 1; k >= 0; k--) if (((m_c[d] >> k) & 1) == 0) lsz = k;
                m_l[d] = lsz;
                if (lsz < w) begin
                    m_s[d] = m_s[d] ^ m_v[d][lsz];
                    m_c[d] = (m_c[d] + 1) % (1 << w);
                    m_w[d] = 0;
                end else begin
                    m_s[d] = 0; m_c[d] = 0; m_w[d] = 1;
                end
            end else begin
                m_w[d] = 0;
            end
`ifdef SOBOL_DIRLOAD_EN
            if (we && idx < w) m_v[d][idx] = data;
`endif
        end
        e = {2'b0, 1'(m_w[d]), 5'(m_l[d]), 16'(m_c[d]), 16'(m_s[d])};
    endtask

    // Driver: one clock cycle of stimulus; the scoreboard compares after the edge.
    task automatic cycle(input bit r, input bit e3, input bit e8,
                         input bit we, input int idx, input int data);
        logic [EW-1:0] x;
        model_step(0, 3, r, e3, we, idx, data, x);
        exp_q3.push_back(x);
        model_step(1, 8, r, e8, 1'b0, 0, 0, x);
        exp_q8.push_back(x);
        rst = r; en3 = e3; en8 = e8; we3 = we; idx3 = 2'(idx); data3 = 3'(data);
        @(posedge clk);
        #1;
        if (exp_q3.size() == 0) begin
            check("w3_queue_empty", 32'd0, 32'd1);
        end else begin
            x = exp_q3.pop_front();
            check("w3_sobol", 32'(sobol3), 32'(x[15:0]));
            check("w3_cnt",   32'(cnt3),   32'(x[31:16]));
            check("w3_lsz",   32'(lsz3),   32'(x[36:32]));
            check("w3_wrap",  32'(wrap3),  32'(x[37]));
        end
        if (exp_q8.size() == 0) begin
            check("w8_queue_empty", 32'd0, 32'd1);
        end else begin
            x = exp_q8.pop_front();
            check("w8_sobol", 32'(sobol8), 32'(x[15:0]));
            check("w8_cnt",   32'(cnt8),   32'(x[31:16]));
            check("w8_lsz",   32'(lsz8),   32'(x[36:32]));
            check("w8_wrap",  32'(wrap8),  32'(x[37]));
        end
    endtask

    initial begin
        int t1_s[9];
        int t1_l[9];
        int tg_s[4];
        int dl_s[8];
        bit seen[256];
        int distinct;
        int wraps;

        t1_s = '{4, 6, 2, 3, 7, 5, 1, 0, 4};
        t1_l = '{0, 1, 0, 2, 0, 1, 0, 3, 0};
        tg_s = '{4, 4, 4, 6};
`ifdef SOBOL_DIRLOAD_EN
        dl_s = '{4, 6, 2, 7, 3, 5, 1, 0};
`else
        dl_s = '{4, 6, 2, 3, 7, 5, 1, 0};
`endif

        // Reset state
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 0, 7);
        check("rst_sobol3", 32'(sobol3), 32'd0);

        // Dimension-1 sequence over one full period plus one
        for (int i = 0; i < 9; i++) begin
            cycle(0, 1, 0, 0, 0, 0);
            check("seq_sobol", 32'(sobol3), 32'(t1_s[i]));
            check("seq_lsz",   32'(lsz3),   32'(t1_l[i]));
            check("seq_wrap",  32'(wrap3),  32'(i == 7));
        end

        // Enable toggled 1,0,0,1: hold, then continue
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, (i == 0 || i == 3), 0, 0, 0, 0);
            check("tog_sobol", 32'(sobol3), 32'(tg_s[i]));
            check("tog_wrap",  32'(wrap3),  32'd0);
        end

        // Reset mid-sequence discards state
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0);
        check("mid_sobol", 32'(sobol3), 32'd7);
        cycle(1, 1, 0, 0, 0, 0);
        check("mid_rst_all", 32'({sobol3, cnt3, lsz3, wrap3}), 32'd0);
        cycle(0, 1, 0, 0, 0, 0);
        check("mid_first_sobol", 32'(sobol3), 32'd4);
        check("mid_first_cnt",   32'(cnt3),   32'd1);

        // WIDTH=8 full period: permutation, single wrap, counter back to 0
        cycle(1, 0, 0, 0, 0, 0);
        distinct = 0;
        wraps = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cycle(0, 0, 1, 0, 0, 0);
            if (!seen[sobol8]) distinct++;
            seen[sobol8] = 1'b1;
            if (wrap8) wraps++;
        end
        check("w8_distinct", 32'(distinct), 32'd256);
        check("w8_wraps",    32'(wraps),    32'd1);
        check("w8_cnt_end",  32'(cnt8),     32'd0);
        cycle(0, 0, 0, 0, 0, 0);
        check("w8_wrap_drop", 32'(wrap8), 32'd0);

        // Direction-vector load (dimension 2 = {4,6,5}); write to index 3 ignored
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 4);
        check("dl_adv0", 32'(sobol3), 32'(dl_s[0]));
        cycle(0, 1, 0, 1, 1, 6);
        check("dl_adv1_old_vec", 32'(sobol3), 32'(dl_s[1]));
        cycle(0, 0, 0, 1, 2, 5);
        cycle(0, 0, 0, 1, 3, 7);
        check("dl_write_hold", 32'(sobol3), 32'(dl_s[1]));
        for (int i = 2; i < 8; i++) begin
            cycle(0, 1, 0, 0, 0, 0);
            check("dl_adv", 32'(sobol3), 32'(dl_s[i]));
        end

        // Random enable/write traffic against the model
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
